// File: rtl/lz77_sch_pkg.sv
// rtl/lz77_sch_pkg.sv - shared types and default sizes for the lz77 scanline scheduler
//
// Purpose : default field widths, row-buffer depth and gap length shared by
//           lz77_sch and lz77_sch_crd, plus the scheduler state type.
// Ports   : none (package).
package lz77_sch_pkg;

  localparam int SIZE_W_WD_DEF   = 12;
  localparam int SIZE_H_WD_DEF   = 12;
  localparam int ROW_BUF_NUM_DEF = 2;
  localparam int GAP_CYC_DEF     = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } sch_state_e;

endpackage

// File: rtl/lz77_sch_crd.sv
// rtl/lz77_sch_crd.sv - saturating up/down row-credit counter
//
// Purpose : counts complete filtered scanlines waiting in the filter FIFO.
// Ports   : clk, rstn     - clock, async active-low reset
//           clr_i         - synchronous clear (frame start)
//           inc_i / dec_i - row pushed by filter / row consumed by lz77_top
//           crd_o         - current credit
//           full_o        - credit at ROW_BUF_NUM (registered decode)
//           ovf_o         - increment attempted while full (same-cycle flag)
module lz77_sch_crd #(
  parameter int ROW_BUF_NUM = 2,
  parameter int CRD_WD      = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [CRD_WD-1:0] crd_o,
  output logic              full_o,
  output logic              ovf_o
);

  localparam logic [CRD_WD-1:0] CRD_MAX = CRD_WD'(ROW_BUF_NUM);

  logic [CRD_WD-1:0] crd_q, crd_d;

  // Simultaneous inc/dec cancel out; a lone increment at the ceiling is
  // dropped and flagged, a lone decrement at zero is dropped silently.
  always_comb begin
    crd_d = crd_q;
    ovf_o = 1'b0;
    if (clr_i) begin
      crd_d = '0;
    end else if (inc_i && !dec_i) begin
      if (crd_q == CRD_MAX) ovf_o = 1'b1;
      else                  crd_d = crd_q + CRD_WD'(1);
    end else if (dec_i && !inc_i) begin
      if (crd_q != '0) crd_d = crd_q - CRD_WD'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) crd_q <= '0;
    else       crd_q <= crd_d;
  end

  assign crd_o  = crd_q;
  assign full_o = (crd_q == CRD_MAX);

endmodule

// File: rtl/lz77_sch.sv
// rtl/lz77_sch.sv - frame-level scheduler issuing one lz77_top start per scanline
//
// Purpose : accepts a frame start, waits for filtered-row credit, pulses
//           lz_start_o once per scanline, inserts GAP_CYC idle cycles between
//           rows, back-pressures the filter and reports frame completion.
// Ports   : clk, rstn                 - clock, async active-low reset
//           cfg_w_i, cfg_h_i, start_i - frame size and start pulse
//           done_o, busy_o, err_o     - frame done pulse, busy, sticky error
//           flt_row_done_i            - filter pushed one full scanline
//           flt_stall_o               - filter FIFO holds ROW_BUF_NUM rows
//           lz_cfg_w_o, lz_cfg_h_o    - latched frame size to lz77_top
//           lz_start_o, lz_done_i     - per-scanline handshake with lz77_top
//           row_idx_o, row_lst_o      - current row index, last-row flag
module lz77_sch
  import lz77_sch_pkg::*;
#(
  parameter int SIZE_W_WD   = SIZE_W_WD_DEF,
  parameter int SIZE_H_WD   = SIZE_H_WD_DEF,
  parameter int ROW_BUF_NUM = ROW_BUF_NUM_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
  input  logic                 start_i,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 err_o,
  input  logic                 flt_row_done_i,
  output logic                 flt_stall_o,
  output logic [SIZE_W_WD-1:0] lz_cfg_w_o,
  output logic [SIZE_H_WD-1:0] lz_cfg_h_o,
  output logic                 lz_start_o,
  input  logic                 lz_done_i,
  output logic [SIZE_H_WD-1:0] row_idx_o,
  output logic                 row_lst_o
);

  localparam int CRD_WD = $clog2(ROW_BUF_NUM + 1);
  localparam int GAP_WD = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [GAP_WD-1:0] GAP_LAST = GAP_WD'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sch_state_e           state_q, state_d;
  logic [SIZE_W_WD-1:0] cfg_w_q, cfg_w_d;
  logic [SIZE_H_WD-1:0] cfg_h_q, cfg_h_d;
  logic [SIZE_H_WD-1:0] row_idx_q, row_idx_d;
  logic [GAP_WD-1:0]    gap_q, gap_d;
  logic                 err_q, err_d;

  logic [CRD_WD-1:0]    crd;
  logic                 crd_full, crd_ovf, crd_clr, crd_inc, crd_dec;
  logic [SIZE_H_WD-1:0] h_m1;
  logic                 row_is_last;

  assign h_m1        = cfg_h_q - SIZE_H_WD'(1);
  assign row_is_last = (row_idx_q == h_m1);
  assign crd_inc     = flt_row_done_i && (state_q != ST_IDLE);
  assign crd_dec     = lz_done_i && (state_q == ST_RUN);

  lz77_sch_crd #(
    .ROW_BUF_NUM (ROW_BUF_NUM),
    .CRD_WD      (CRD_WD)
  ) u_crd (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (crd_clr),
    .inc_i  (crd_inc),
    .dec_i  (crd_dec),
    .crd_o  (crd),
    .full_o (crd_full),
    .ovf_o  (crd_ovf)
  );

  always_comb begin
    state_d   = state_q;
    cfg_w_d   = cfg_w_q;
    cfg_h_d   = cfg_h_q;
    row_idx_d = row_idx_q;
    gap_d     = gap_q;
    err_d     = err_q;
    crd_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cfg_w_d   = cfg_w_i;
          cfg_h_d   = cfg_h_i;
          row_idx_d = '0;
          err_d     = 1'b0;
          crd_clr   = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      // Zero-size check happens on the latched values, one cycle after accept.
      ST_WAIT: begin
        if (cfg_w_q == '0 || cfg_h_q == '0) state_d = ST_DONE;
        else if (crd != '0)                 state_d = ST_START;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (lz_done_i) begin
          if (row_is_last) begin
            state_d = ST_DONE;
          end else begin
            row_idx_d = row_idx_q + SIZE_H_WD'(1);
            gap_d     = '0;
            state_d   = (GAP_CYC == 0) ? ST_WAIT : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_WAIT;
        else                   gap_d   = gap_q + GAP_WD'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Error setting wins over the clear from an accepted start.
    if (crd_ovf || (lz_done_i && state_q != ST_RUN) ||
        (flt_row_done_i && state_q == ST_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cfg_w_q   <= '0;
      cfg_h_q   <= '0;
      row_idx_q <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_w_q   <= cfg_w_d;
      cfg_h_q   <= cfg_h_d;
      row_idx_q <= row_idx_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
    end
  end

  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;
  assign flt_stall_o = crd_full;
  assign lz_cfg_w_o  = cfg_w_q;
  assign lz_cfg_h_o  = cfg_h_q;
  assign lz_start_o  = (state_q == ST_START);
  assign row_idx_o   = row_idx_q;
  assign row_lst_o   = (state_q == ST_START) && row_is_last;

endmodule

// File: tb/tb_lz77_sch.sv
// tb/tb_lz77_sch.sv - directed self-checking bench for lz77_sch
module tb_lz77_sch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] cfg_w_i, cfg_h_i;
  logic        start_i, flt_row_done_i, lz_done_i;
  logic        done_o, busy_o, err_o, flt_stall_o, lz_start_o, row_lst_o;
  logic [11:0] lz_cfg_w_o, lz_cfg_h_o, row_idx_o;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;
  int n_lst    = 0;
  int n_done   = 0;

  lz77_sch dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_w_i        (cfg_w_i),
    .cfg_h_i        (cfg_h_i),
    .start_i        (start_i),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .flt_row_done_i (flt_row_done_i),
    .flt_stall_o    (flt_stall_o),
    .lz_cfg_w_o     (lz_cfg_w_o),
    .lz_cfg_h_o     (lz_cfg_h_o),
    .lz_start_o     (lz_start_o),
    .lz_done_i      (lz_done_i),
    .row_idx_o      (row_idx_o),
    .row_lst_o      (row_lst_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lz_start_o) n_start++;
    if (lz_start_o && row_lst_o) n_lst++;
    if (done_o) n_done++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_flt();
    flt_row_done_i = 1'b1; cyc(); flt_row_done_i = 1'b0;
  endtask

  task automatic pulse_lzd();
    lz_done_i = 1'b1; cyc(); lz_done_i = 1'b0;
  endtask

  task automatic start_frame(input logic [11:0] w, input logic [11:0] h);
    cfg_w_i = w; cfg_h_i = h; start_i = 1'b1; cyc(); start_i = 1'b0;
  endtask

  // Edges from the current point until lz_start_o is seen, bounded.
  task automatic wait_start(input string tag, input int exp_n,
                            input logic [11:0] exp_idx, input logic exp_lst);
    int n = 0;
    do begin cyc(); n++; end while (!lz_start_o && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_idx"}, 32'(row_idx_o), 32'(exp_idx));
    chk({tag, "_lst"}, 32'(row_lst_o), 32'(exp_lst));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_stall"}, 32'(flt_stall_o), 0);
    chk({tag, "_start"}, 32'(lz_start_o), 0);
    chk({tag, "_lst"}, 32'(row_lst_o), 0);
    chk({tag, "_cfgw"}, 32'(lz_cfg_w_o), 0);
    chk({tag, "_cfgh"}, 32'(lz_cfg_h_o), 0);
    chk({tag, "_row"}, 32'(row_idx_o), 0);
  endtask

  initial begin
    rstn = 1'b0; cfg_w_i = '0; cfg_h_i = '0;
    start_i = 1'b0; flt_row_done_i = 1'b0; lz_done_i = 1'b0;
    cyc(); cyc();
    chk_all_zero("rst");
    rstn = 1'b1;
    cyc();

    // Normal frame h=4 w=256
    start_frame(12'd256, 12'd4);
    chk("t1_busy", 32'(busy_o), 1);
    chk("t1_cfgw", 32'(lz_cfg_w_o), 256);
    chk("t1_cfgh", 32'(lz_cfg_h_o), 4);
    pulse_flt();
    chk("t1_nostart", 32'(lz_start_o), 0);
    wait_start("t1_r0", 1, 12'd0, 1'b0);
    cyc();
    pulse_flt();
    chk("t1_stall_full", 32'(flt_stall_o), 1);
    pulse_lzd();
    chk("t1_stall_rel", 32'(flt_stall_o), 0);
    wait_start("t1_r1", 3, 12'd1, 1'b0);
    cyc(); pulse_flt(); pulse_lzd();
    wait_start("t1_r2", 3, 12'd2, 1'b0);
    cyc(); pulse_flt(); pulse_lzd();
    wait_start("t1_r3", 3, 12'd3, 1'b1);
    cyc(); pulse_lzd();
    chk("t1_done", 32'(done_o), 1);
    chk("t1_busy_done", 32'(busy_o), 1);
    cyc();
    chk("t1_done_fall", 32'(done_o), 0);
    chk("t1_busy_fall", 32'(busy_o), 0);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_nstart", 32'(n_start), 4);
    chk("t1_nlst", 32'(n_lst), 1);

    // Credit stall/overflow, then simultaneous inc/dec, h=3
    start_frame(12'd8, 12'd3);
    chk("t2_clr_stall", 32'(flt_stall_o), 0);
    pulse_flt();
    pulse_flt();
    chk("t2_stall", 32'(flt_stall_o), 1);
    chk("t2_err0", 32'(err_o), 0);
    pulse_flt();
    chk("t2_ovf_err", 32'(err_o), 1);
    chk("t2_ovf_stall", 32'(flt_stall_o), 1);
    pulse_lzd();
    chk("t2_sat", 32'(flt_stall_o), 0);
    wait_start("t2_r1", 3, 12'd1, 1'b0);
    cyc();
    flt_row_done_i = 1'b1; lz_done_i = 1'b1; cyc();
    flt_row_done_i = 1'b0; lz_done_i = 1'b0;
    chk("t3_sim_stall", 32'(flt_stall_o), 0);
    chk("t3_sim_row", 32'(row_idx_o), 2);
    wait_start("t3_r2", 3, 12'd2, 1'b1);
    cyc(); pulse_lzd();
    chk("t2_done", 32'(done_o), 1);
    chk("t2_err_sticky", 32'(err_o), 1);
    cyc();
    chk("t2_nstart", 32'(n_start), 7);

    // Zero height
    start_frame(12'd16, 12'd0);
    chk("t4_err_clr", 32'(err_o), 0);
    chk("t4_busy", 32'(busy_o), 1);
    chk("t4_done_early", 32'(done_o), 0);
    cyc();
    chk("t4_done", 32'(done_o), 1);
    cyc();
    chk("t4_idle", 32'(busy_o), 0);
    chk("t4_nstart", 32'(n_start), 7);

    // Protocol errors, then reset during row 2
    start_frame(12'd32, 12'd2);
    pulse_lzd();
    chk("t5_spur_err", 32'(err_o), 1);
    start_frame(12'd99, 12'd7);
    chk("t5_ign_w", 32'(lz_cfg_w_o), 32);
    chk("t5_ign_h", 32'(lz_cfg_h_o), 2);
    chk("t5_ign_busy", 32'(busy_o), 1);
    cfg_w_i = '0; cfg_h_i = '0;
    pulse_flt();
    wait_start("t5_r0", 1, 12'd0, 1'b0);
    cyc(); pulse_flt(); pulse_lzd();
    wait_start("t5_r1", 3, 12'd1, 1'b1);
    cyc();
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    cyc();
    rstn = 1'b1;
    cyc();
    chk("t6_nodone", 32'(n_done), 3);

    // Fresh frame h=1 after reset
    start_frame(12'd5, 12'd1);
    pulse_flt();
    wait_start("t6_r0", 1, 12'd0, 1'b1);
    cyc(); pulse_lzd();
    chk("t6_done", 32'(done_o), 1);
    cyc();
    chk("t6_idle", 32'(busy_o), 0);
    chk("t6_err", 32'(err_o), 0);

    // Filter row in IDLE
    pulse_flt();
    chk("t7_idle_flt_err", 32'(err_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
